rriot_bus_arbiter: RTL and testbench
====================================

# rriot_bus_arbiter

Two-port bus arbiter and access sequencer for the `mcs6530` RRIOT core. It sits between two requesters and the single `mcs6530` register/ROM/RAM bus. Requester 0 is the CPU-side model and requester 1 is the host/debug injector. It grants the bus round-robin, optionally honours a bounded lock for read-modify-write sequences, and drives one two-cycle access at a time, returning read data with a completion pulse.

## Interface
Parameters:
- `AW`, 10, address width (matches `mcs6530` `A`)
- `DW`, 8, data width
- `MAX_LOCK`, 4, maximum consecutive locked accesses by one owner while the other port is requesting; legal range 1..15

Ports:
- `phi2`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `mN_req`  in  1  request; N = 0,1; held with payload until `mN_gnt`
- `mN_we_n`  in  1  0 = write, 1 = read
- `mN_rs_n`  in  1  ROM-select for the access, active-low
- `mN_addr`  in  AW  access address
- `mN_wdata`  in  DW  write data
- `mN_lock`  in  1  request that the next access stays with this owner
- `mN_gnt`  out  1  one-cycle pulse; payload captured
- `mN_done`  out  1  one-cycle pulse; access complete
- `mN_rdata`  out  DW  read result; valid while `mN_done` = 1, held until that port's next done
- `bus_a`  out  AW  to `mcs6530` `A`
- `bus_di`  out  DW  to `mcs6530` `DI`
- `bus_do`  in  DW  from `mcs6530` `DO`
- `bus_oe`  in  1  from `mcs6530` `OE`
- `bus_we_n`  out  1  to `mcs6530` `we_n`
- `bus_rs_n`  out  1  to `mcs6530` `RS_n`

## Operation
- States: IDLE, ADDR, DATA.
- **IDLE:**
  - If no request, stay in IDLE.
  - Otherwise choose the owner, latch its payload, and go to ADDR with `mN_gnt` = 1 for that cycle.
- **Arbitration:**
  - If one port requests, that port wins.
  - If both request, the port not equal to `last_owner` wins.
  - `last_owner` resets to 1, so m0 wins the first tie.
  - `last_owner` updates on every grant.
- **ADDR:**
  - Drive `bus_a`, `bus_rs_n`, and `bus_di` from the latched payload.
  - `bus_we_n` = latched `we_n`, so the write strobe is low for exactly this one cycle.
  - Next state is always DATA.
- **DATA:**
  - `bus_a`, `bus_rs_n`, and `bus_di` are held.
  - `bus_we_n` = 1.
  - At the end of the cycle, capture `mN_rdata`:
    - read with `bus_oe` = 1: capture `bus_do`
    - read with `bus_oe` = 0: capture 8'hFF (open bus)
    - write: `mN_rdata` is unchanged
  - Pulse `mN_done` in the following cycle.
- **Next state after DATA:**
  - **Lock continuation:** if the owner's `req` = 1 and its `lock` was 1 when it was granted, and `lock_cnt` < `MAX_LOCK` or the other port is idle, re-grant the same owner, go to ADDR, and increment `lock_cnt`.
  - Else if any request is pending, arbitrate as in IDLE, go to ADDR, and reset `lock_cnt` to 1.
  - Else go to IDLE and reset `lock_cnt` to 0.
- `lock_cnt` is 4 bits, saturates at 15, and counts grants in the current chain.
- Back-to-back throughput is one access per 2 cycles. `mN_done` for access k coincides with the `gnt` of access k+1.
- **Idle bus values:** `bus_a` = 0, `bus_di` = 0, `bus_we_n` = 1, `bus_rs_n` = 1.
- Only the latched payload drives the bus; requester inputs changing after `gnt` have no effect.

## Timing
- **Reset values:**
  - state = IDLE
  - all `gnt` and `done` = 0
  - both `mN_rdata` = 0
  - bus outputs at idle values
  - `last_owner` = 1, `lock_cnt` = 0
- **Latency:** `req` sampled high at edge E (in IDLE) → `gnt` high in cycle E+1 (ADDR) → DATA in cycle E+2 → `done` and `rdata` in cycle E+3.
- **Handshake:**
  - The requester drops `req` no later than the edge after `gnt`.
  - `req` still high at the DATA-end edge is treated as a new request.
  - `gnt` and `done` are registered outputs, never combinational from inputs.
- **Simultaneous events:**
  - Both requests arriving in the same cycle are resolved by round-robin.
  - A lock continuation takes precedence over round-robin until `MAX_LOCK` is reached, then forced release occurs only if the other port is requesting.
- **Reset mid-operation:**
  - Asserting `rst_n` in ADDR or DATA abandons the access.
  - No `done` is issued and `bus_we_n` returns to 1 immediately (asynchronously).
  - After release, the block restarts in IDLE.

## Test plan
- **Single write then read:** m0 writes addr 0x3C5 = 0xA5 (RAM), then reads 0x3C5.
  - Write: `m0_gnt` at E+1, `bus_we_n` low only at E+1, `m0_done` at E+3.
  - Read: `m0_rdata` = 0xA5 with `m0_done`.
- **Tie after reset:** m0 and m1 raise `req` in the same cycle → `m0_gnt` at E+1, `m1_gnt` at E+3, `m0_done` at E+3, `m1_done` at E+5.
- **Round-robin:** both ports re-request continuously for 6 accesses → grants alternate 0,1,0,1,0,1 with 2-cycle spacing.
- **Lock bound:** m1 holds `lock` = 1 and `req` for 10 accesses while m0 requests, with `MAX_LOCK` = 4 → m1 receives 4 consecutive grants, then m0, then m1 again; with m0 idle, m1 receives all 10 consecutively.
- **Reset mid-access:** m0 starts a write; `rst_n` goes low during DATA for 2 cycles → no `m0_done`, `bus_we_n` = 1, `bus_a` = 0; the next request after release is granted at E+1.
- **Open bus:** m1 read with `bus_oe` held 0 and `bus_do` = 0x5A → `m1_rdata` = 0xFF at `m1_done`; a following read with `bus_oe` = 1 → `m1_rdata` = 0x5A.

Source files
------------

// File: rtl/rriot_bus_arbiter_if.sv
// rriot_bus_arbiter_if
//   Connects the two requesters and the mcs6530 register/ROM/RAM bus to
//   rriot_bus_arbiter.
//   mN_req/we_n/rs_n/addr/wdata/lock : requester N access request and payload
//   mN_gnt/done/rdata                : grant pulse, completion pulse, read data
//   bus_a/di/we_n/rs_n               : arbiter drive towards the mcs6530
//   bus_do/oe                        : mcs6530 read data and output enable
//   slave  modport : the arbiter's view
//   master modport : the requester/device side's view
interface rriot_bus_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          m0_req;
    logic          m0_we_n;
    logic          m0_rs_n;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_lock;
    logic          m0_gnt;
    logic          m0_done;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we_n;
    logic          m1_rs_n;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_done;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] bus_a;
    logic [DW-1:0] bus_di;
    logic [DW-1:0] bus_do;
    logic          bus_oe;
    logic          bus_we_n;
    logic          bus_rs_n;

    modport slave (
        input  m0_req, m0_we_n, m0_rs_n, m0_addr, m0_wdata, m0_lock,
        output m0_gnt, m0_done, m0_rdata,
        input  m1_req, m1_we_n, m1_rs_n, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_done, m1_rdata,
        output bus_a, bus_di, bus_we_n, bus_rs_n,
        input  bus_do, bus_oe
    );

    modport master (
        output m0_req, m0_we_n, m0_rs_n, m0_addr, m0_wdata, m0_lock,
        input  m0_gnt, m0_done, m0_rdata,
        output m1_req, m1_we_n, m1_rs_n, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_done, m1_rdata,
        input  bus_a, bus_di, bus_we_n, bus_rs_n,
        output bus_do, bus_oe
    );
endinterface

// File: rtl/rriot_bus_arbiter.sv
// rriot_bus_arbiter
//   Two-port round-robin arbiter and two-cycle access sequencer in front of
//   the mcs6530 RRIOT bus. Port 0 is the CPU-side model, port 1 the
//   host/debug injector. A granted owner may keep the bus for a bounded
//   chain of locked accesses.
//   phi2    : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   arb_bus : requester handshakes/payloads and the mcs6530 bus (slave view)
module rriot_bus_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 4
) (
    input logic                 phi2,
    input logic                 rst_n,
    rriot_bus_arbiter_if.slave  arb_bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);

    state_t        state_q, state_d;
    logic          owner_q;
    logic          last_owner_q;
    logic [3:0]    lock_cnt_q, lock_cnt_d;
    logic          lat_we_n;
    logic          lat_rs_n;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_lock;
    logic [1:0]    gnt_q;
    logic [1:0]    done_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic [1:0]    req;
    logic          rr_pick;
    logic          grant;
    logic          grant_id;
    logic [DW-1:0] read_value;

    assign req = {arb_bus.m1_req, arb_bus.m0_req};

    // On a tie the port that did not own the bus last wins; otherwise the
    // single requester wins.
    assign rr_pick = (req[0] && req[1]) ? ~last_owner_q : req[1];

    // A read with the device output disabled sees an undriven (high) bus.
    assign read_value = arb_bus.bus_oe ? arb_bus.bus_do : '1;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        grant      = 1'b0;
        grant_id   = owner_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = ADDR;
                    grant      = 1'b1;
                    grant_id   = rr_pick;
                    lock_cnt_d = 4'd1;
                end
            end
            ADDR: begin
                state_d = DATA;
            end
            DATA: begin
                // Lock continuation beats round-robin until the chain hits the
                // bound, and past the bound only while the other port is idle.
                if (req[owner_q] && lat_lock &&
                    ((lock_cnt_q < LOCK_LIMIT) || !req[~owner_q])) begin
                    state_d    = ADDR;
                    grant      = 1'b1;
                    grant_id   = owner_q;
                    lock_cnt_d = (lock_cnt_q == 4'hF) ? 4'hF : lock_cnt_q + 4'd1;
                end else if (|req) begin
                    state_d    = ADDR;
                    grant      = 1'b1;
                    grant_id   = rr_pick;
                    lock_cnt_d = 4'd1;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            lock_cnt_q   <= '0;
            lat_we_n     <= 1'b1;
            lat_rs_n     <= 1'b1;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_lock     <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= '0;
            done_q     <= '0;
            if (grant) begin
                gnt_q[grant_id] <= 1'b1;
                owner_q         <= grant_id;
                last_owner_q    <= grant_id;
                lat_we_n        <= grant_id ? arb_bus.m1_we_n  : arb_bus.m0_we_n;
                lat_rs_n        <= grant_id ? arb_bus.m1_rs_n  : arb_bus.m0_rs_n;
                lat_addr        <= grant_id ? arb_bus.m1_addr  : arb_bus.m0_addr;
                lat_wdata       <= grant_id ? arb_bus.m1_wdata : arb_bus.m0_wdata;
                lat_lock        <= grant_id ? arb_bus.m1_lock  : arb_bus.m0_lock;
            end
            if (state_q == DATA) begin
                done_q[owner_q] <= 1'b1;
                if (lat_we_n) begin
                    if (owner_q) begin
                        rdata1_q <= read_value;
                    end else begin
                        rdata0_q <= read_value;
                    end
                end
            end
        end
    end

    // Bus drive comes only from the latched payload; the write strobe is
    // confined to the address cycle and falls back to idle values on reset.
    always_comb begin
        arb_bus.bus_a    = '0;
        arb_bus.bus_di   = '0;
        arb_bus.bus_rs_n = 1'b1;
        arb_bus.bus_we_n = 1'b1;
        if (state_q != IDLE) begin
            arb_bus.bus_a    = lat_addr;
            arb_bus.bus_di   = lat_wdata;
            arb_bus.bus_rs_n = lat_rs_n;
        end
        if (state_q == ADDR) begin
            arb_bus.bus_we_n = lat_we_n;
        end
    end

    assign arb_bus.m0_gnt   = gnt_q[0];
    assign arb_bus.m1_gnt   = gnt_q[1];
    assign arb_bus.m0_done  = done_q[0];
    assign arb_bus.m1_done  = done_q[1];
    assign arb_bus.m0_rdata = rdata0_q;
    assign arb_bus.m1_rdata = rdata1_q;
endmodule

// File: tb/tb_rriot_bus_arbiter.sv
// tb_rriot_bus_arbiter
//   Randomized two-requester traffic against rriot_bus_arbiter with a
//   memory-backed mcs6530 stand-in and a transaction-level reference model.
module tb_rriot_bus_arbiter;
    localparam int AW       = 10;
    localparam int DW       = 8;
    localparam int MAX_LOCK = 4;

    logic phi2;
    logic rst_n;

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    rriot_bus_arbiter_if #(.AW(AW), .DW(DW)) arb_bus ();

    rriot_bus_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .phi2    (phi2),
        .rst_n   (rst_n),
        .arb_bus (arb_bus)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- device stand-in ----------------
    logic [DW-1:0] devmem [1024];
    logic          oe;

    assign arb_bus.bus_do = devmem[arb_bus.bus_a];
    assign arb_bus.bus_oe = oe;

    always @(posedge phi2) begin
        if (!arb_bus.bus_we_n) devmem[arb_bus.bus_a] <= arb_bus.bus_di;
    end

    // ---------------- requesters ----------------
    logic [1:0]    r_req, r_we_n, r_rs_n, r_lock;
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];
    int unsigned   p_req [2], p_keep [2], p_lock [2], p_oe;

    task automatic new_payload(input int p);
        r_we_n[p]  = 1'($urandom_range(0, 1));
        r_rs_n[p]  = 1'($urandom_range(0, 1));
        r_addr[p]  = AW'(10'h3C0 + $urandom_range(0, 15));
        r_wdata[p] = DW'($urandom);
        r_lock[p]  = ($urandom_range(0, 99) < p_lock[p]);
    endtask

    task automatic drive_ports();
        arb_bus.m0_req   = r_req[0];
        arb_bus.m0_we_n  = r_we_n[0];
        arb_bus.m0_rs_n  = r_rs_n[0];
        arb_bus.m0_addr  = r_addr[0];
        arb_bus.m0_wdata = r_wdata[0];
        arb_bus.m0_lock  = r_lock[0];
        arb_bus.m1_req   = r_req[1];
        arb_bus.m1_we_n  = r_we_n[1];
        arb_bus.m1_rs_n  = r_rs_n[1];
        arb_bus.m1_addr  = r_addr[1];
        arb_bus.m1_wdata = r_wdata[1];
        arb_bus.m1_lock  = r_lock[1];
    endtask

    task automatic step_requesters();
        logic [1:0] g;
        g = {arb_bus.m1_gnt, arb_bus.m0_gnt};
        for (int p = 0; p < 2; p++) begin
            if (!rst_n) begin
                r_req[p] = 1'b0;
            end else if (r_req[p] && g[p]) begin
                if ($urandom_range(0, 99) < p_keep[p]) begin
                    new_payload(p);
                end else begin
                    r_req[p] = 1'b0;
                    new_payload(p);
                end
            end else if (!r_req[p]) begin
                r_req[p] = ($urandom_range(0, 99) < p_req[p]);
                new_payload(p);
            end
        end
        oe = ($urandom_range(0, 99) < p_oe);
        drive_ports();
    endtask

    // ---------------- reference model ----------------
    // slot: 0 = bus free, 1 = address cycle, 2 = data cycle of current access
    int            slot, cur, mlast, chain;
    logic          m_we_n, m_rs_n, m_lock;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] shadow [1024];
    logic [1:0]    e_gnt, e_done;
    logic [DW-1:0] e_rdata [2];

    task automatic model_reset();
        slot  = 0;
        cur   = 0;
        mlast = 1;
        chain = 0;
        e_gnt = '0;
        e_done = '0;
        e_rdata[0] = '0;
        e_rdata[1] = '0;
    endtask

    task automatic step_model();
        int win;
        e_gnt  = '0;
        e_done = '0;
        if (slot == 1) begin
            slot = 2;
            if (!m_we_n) shadow[m_addr] = m_wdata;
            return;
        end
        if (slot == 2) begin
            e_done[cur] = 1'b1;
            if (m_we_n) e_rdata[cur] = oe ? shadow[m_addr] : 8'hFF;
        end
        win = -1;
        if (slot == 2 && r_req[cur] && m_lock && (chain < MAX_LOCK || !r_req[1-cur])) begin
            win   = cur;
            chain = (chain < 15) ? chain + 1 : 15;
        end else if (r_req != 2'b00) begin
            win   = (r_req == 2'b11) ? 1 - mlast : (r_req[0] ? 0 : 1);
            chain = 1;
        end else begin
            chain = 0;
        end
        if (win >= 0) begin
            cur        = win;
            mlast      = win;
            e_gnt[win] = 1'b1;
            m_we_n     = r_we_n[win];
            m_rs_n     = r_rs_n[win];
            m_addr     = r_addr[win];
            m_wdata    = r_wdata[win];
            m_lock     = r_lock[win];
            slot       = 1;
        end else begin
            slot = 0;
        end
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge phi2);
            if (!rst_n) model_reset();
            else step_model();
        end
    end

    // ---------------- output checks, away from the active edge ----------------
    initial begin : checker_proc
        logic [AW-1:0] xa;
        logic [DW-1:0] xdi;
        logic          xwe, xrs;
        forever begin
            @(negedge phi2);
            if (!rst_n) begin
                check("rst_m0_gnt", arb_bus.m0_gnt, 0);
                check("rst_m1_gnt", arb_bus.m1_gnt, 0);
                check("rst_m0_done", arb_bus.m0_done, 0);
                check("rst_m1_done", arb_bus.m1_done, 0);
                check("rst_m0_rdata", arb_bus.m0_rdata, 0);
                check("rst_m1_rdata", arb_bus.m1_rdata, 0);
                check("rst_bus_a", arb_bus.bus_a, 0);
                check("rst_bus_di", arb_bus.bus_di, 0);
                check("rst_bus_we_n", arb_bus.bus_we_n, 1);
                check("rst_bus_rs_n", arb_bus.bus_rs_n, 1);
            end else begin
                xa = '0; xdi = '0; xwe = 1'b1; xrs = 1'b1;
                if (slot != 0) begin
                    xa  = m_addr;
                    xdi = m_wdata;
                    xrs = m_rs_n;
                end
                if (slot == 1) xwe = m_we_n;
                check("m0_gnt", arb_bus.m0_gnt, e_gnt[0]);
                check("m1_gnt", arb_bus.m1_gnt, e_gnt[1]);
                check("m0_done", arb_bus.m0_done, e_done[0]);
                check("m1_done", arb_bus.m1_done, e_done[1]);
                check("m0_rdata", arb_bus.m0_rdata, e_rdata[0]);
                check("m1_rdata", arb_bus.m1_rdata, e_rdata[1]);
                check("bus_a", arb_bus.bus_a, xa);
                check("bus_di", arb_bus.bus_di, xdi);
                check("bus_we_n", arb_bus.bus_we_n, xwe);
                check("bus_rs_n", arb_bus.bus_rs_n, xrs);
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic set_knobs(input int unsigned q0, k0, l0, q1, k1, l1, o);
        p_req[0] = q0; p_keep[0] = k0; p_lock[0] = l0;
        p_req[1] = q1; p_keep[1] = k1; p_lock[1] = l1;
        p_oe = o;
    endtask

    initial begin : main_proc
        int unsigned cyc;
        int unsigned rst_at [3];
        logic [DW-1:0] v;
        rst_at[0] = 2;
        rst_at[1] = 700 + $urandom_range(0, 20);
        rst_at[2] = 1900 + $urandom_range(0, 20);
        for (int i = 0; i < 1024; i++) begin
            v = DW'($urandom);
            devmem[i] = v;
            shadow[i] = v;
        end
        r_req = '0; r_we_n = '1; r_rs_n = '1; r_lock = '0;
        r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0;
        oe = 1'b1;
        set_knobs(0, 0, 0, 0, 0, 0, 75);
        drive_ports();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cyc = 0;
        while (cyc < 3600) begin
            @(posedge phi2);
            #1;
            if (cyc == 5)    set_knobs(30, 30, 30, 30, 30, 30, 75);
            if (cyc == 1500) set_knobs(90, 90, 10, 90, 90, 95, 50);
            if (cyc == 2600) set_knobs(0, 0, 0, 95, 97, 97, 75);
            if (cyc == 3200) set_knobs(60, 50, 50, 60, 50, 50, 25);
            step_requesters();
            for (int k = 0; k < 3; k++) begin
                if (cyc == rst_at[k] + 2) begin
                    #2 rst_n = 1'b1;
                end else if (cyc == rst_at[k] && k != 0) begin
                    #2 rst_n = 1'b0;
                end
            end
            cyc++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
